// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack ROM boot loader: ROM geometry, the loader
// state encoding and a helper that says which states take a stream byte.
// No ports (package).
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam int HACK_ROM_ADDR_W = 15;
    localparam int HACK_WORD_W     = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DAT_HI,
        ST_DAT_LO,
        ST_WRITE,
        ST_CHK_HI,
        ST_CHK_LO,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // States in which the loader consumes a byte from the stream
    function automatic logic acceptsByte(input loader_state_t s);
        return (s inside {ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO,
                          ST_CHK_HI, ST_CHK_LO});
    endfunction

endpackage

// File: rtl/hack_word_assembler.sv
// -----------------------------------------------------------------------------
// hack_word_assembler
// Pairs big-endian bytes into 16-bit words and keeps the running checksum of
// the image words.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   i_clear       zero the checksum (start of a new load)
//   i_load_hi     latch i_byte as the high byte of the next pair
//   i_load_lo     form a data word from the latched high byte and i_byte,
//                 register it on o_word and add it to the checksum
//   i_byte        stream byte
//   o_pair        {latched high byte, i_byte}, used for length/checksum fields
//   o_word        last assembled data word (drives the ROM write data)
//   o_checksum    sum of all data words mod 2^16
// -----------------------------------------------------------------------------
module hack_word_assembler
    import hack_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_load_hi,
    input  logic                   i_load_lo,
    input  logic [7:0]             i_byte,
    output logic [HACK_WORD_W-1:0] o_pair,
    output logic [HACK_WORD_W-1:0] o_word,
    output logic [HACK_WORD_W-1:0] o_checksum
);

    logic [7:0]             r_hiByte;
    logic [HACK_WORD_W-1:0] r_word;
    logic [HACK_WORD_W-1:0] r_checksum;

    // The pair is combinational so the FSM can judge the length and checksum
    // fields in the same cycle the low byte is transferred
    assign o_pair     = {r_hiByte, i_byte};
    assign o_word     = r_word;
    assign o_checksum = r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hiByte   <= '0;
            r_word     <= '0;
            r_checksum <= '0;
        end else begin
            if (i_load_hi) begin
                r_hiByte <= i_byte;
            end
            if (i_clear) begin
                r_checksum <= '0;
            end else if (i_load_lo) begin
                r_word     <= {r_hiByte, i_byte};
                r_checksum <= r_checksum + {r_hiByte, i_byte};
            end
        end
    end

endmodule

// File: rtl/hack_rom_loader.sv
// -----------------------------------------------------------------------------
// hack_rom_loader
// Boot-time writer for the Hack instruction ROM. Takes a length-prefixed,
// checksummed byte stream, writes the words to ROM from address 0 and keeps
// the CPU held in reset until a verified image is in place.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   start        pulse; begins a load from IDLE, DONE or ERR
//   byte_valid   source presents byte_data
//   byte_data    stream byte
//   byte_ready   loader takes a byte this cycle (registered)
//   rom_we       one-cycle ROM write strobe per word
//   rom_addr     ROM write address
//   rom_data     ROM write data
//   cpu_hold     high keeps the CPU/PC in reset
//   done         image loaded with a good checksum
//   error        bad length or checksum mismatch
// -----------------------------------------------------------------------------
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W    = HACK_ROM_ADDR_W,
    parameter int MAX_WORDS = 32768
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [HACK_WORD_W-1:0] rom_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    loader_state_t          r_state;
    loader_state_t          w_nextState;
    logic                   r_byteReady;
    logic                   r_romWe;
    logic [ADDR_W-1:0]      r_romAddr;
    logic                   r_cpuHold;
    logic                   r_done;
    logic                   r_error;
    logic [HACK_WORD_W-1:0] r_wordCount;
    logic [HACK_WORD_W-1:0] r_len;

    logic                   w_transfer;
    logic                   w_clear;
    logic                   w_loadHi;
    logic                   w_loadLo;
    logic [HACK_WORD_W-1:0] w_pair;
    logic [HACK_WORD_W-1:0] w_word;
    logic [HACK_WORD_W-1:0] w_checksum;

    assign w_transfer = byte_valid && r_byteReady;

    hack_word_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_load_hi  (w_loadHi),
        .i_load_lo  (w_loadLo),
        .i_byte     (byte_data),
        .o_pair     (w_pair),
        .o_word     (w_word),
        .o_checksum (w_checksum)
    );

    // Next-state decode and assembler strobes. The length and checksum
    // fields reuse the assembler's high-byte latch.
    always_comb begin
        w_nextState = r_state;
        w_clear     = 1'b0;
        w_loadHi    = 1'b0;
        w_loadLo    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_nextState = ST_LEN_HI;
                    w_clear     = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (w_transfer) begin
                    w_loadHi    = 1'b1;
                    w_nextState = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_transfer) begin
                    if ((w_pair == '0) || ({16'd0, w_pair} > 32'(MAX_WORDS))) begin
                        w_nextState = ST_ERR;
                    end else begin
                        w_nextState = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (w_transfer) begin
                    w_loadHi    = 1'b1;
                    w_nextState = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (w_transfer) begin
                    w_loadLo    = 1'b1;
                    w_nextState = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if ((r_wordCount + 16'd1) == r_len) begin
                    w_nextState = ST_CHK_HI;
                end else begin
                    w_nextState = ST_DAT_HI;
                end
            end
            ST_CHK_HI: begin
                if (w_transfer) begin
                    w_loadHi    = 1'b1;
                    w_nextState = ST_CHK_LO;
                end
            end
            ST_CHK_LO: begin
                if (w_transfer) begin
                    w_nextState = (w_pair == w_checksum) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state, so every
    // flag lines up with the state it describes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_byteReady <= 1'b0;
            r_romWe     <= 1'b0;
            r_romAddr   <= '0;
            r_cpuHold   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wordCount <= '0;
            r_len       <= '0;
        end else begin
            r_state     <= w_nextState;
            r_byteReady <= acceptsByte(w_nextState);
            r_romWe     <= (w_nextState == ST_WRITE);
            r_done      <= (w_nextState == ST_DONE);
            r_error     <= (w_nextState == ST_ERR);
            r_cpuHold   <= (w_nextState != ST_DONE);
            if (w_clear) begin
                r_romAddr   <= '0;
                r_wordCount <= '0;
            end else if (r_state == ST_WRITE) begin
                r_romAddr   <= r_romAddr + ADDR_W'(1);
                r_wordCount <= r_wordCount + 16'd1;
            end
            if ((r_state == ST_LEN_LO) && w_transfer) begin
                r_len <= w_pair;
            end
        end
    end

    assign byte_ready = r_byteReady;
    assign rom_we     = r_romWe;
    assign rom_addr   = r_romAddr;
    assign rom_data   = w_word;
    assign cpu_hold   = r_cpuHold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_hack_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_rom_loader
// Self-checking bench for hack_rom_loader: a table of whole images with their
// expected outcome, a few hand sequences for latency and reset-in-flight, and
// random images judged by an image-level reference model.
// -----------------------------------------------------------------------------
module tb_hack_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    hack_rom_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    bit streamTimeout;

    // Writes observed on the ROM port
    logic [14:0] wrAddrQ[$];
    logic [15:0] wrDataQ[$];
    logic        prevWe = 1'b0;

    // Expected outcome produced by the reference model
    logic        expDone;
    logic        expErr;
    logic [14:0] expAddr;
    logic [14:0] expAddrQ[$];
    logic [15:0] expDataQ[$];

    typedef struct packed {
        logic [95:0] stream;
        logic [3:0]  nbytes;
        logic        expDone;
        logic        expErr;
        logic [3:0]  expWrites;
        logic [14:0] expAddr;
    } vec_t;

    vec_t vectors[7];

    // Record every write strobe and insist each lasts one cycle
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wrAddrQ.push_back(rom_addr);
            wrDataQ.push_back(rom_data);
            assertCount++;
            if (prevWe !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL rom_we_pulse: got back-to-back strobes, required single cycle");
            end
        end
        prevWe = rom_we;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Image-level reference: parse the stream per the format rules
    task automatic modelImage(input logic [7:0] q[$]);
        int n;
        int sum;
        int chk;
        int w;
        expAddrQ.delete();
        expDataQ.delete();
        n   = q[0] * 256 + q[1];
        sum = 0;
        if (n == 0 || n > 32768) begin
            expDone = 1'b0;
            expErr  = 1'b1;
            expAddr = 15'd0;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = q[2 + 2 * i] * 256 + q[3 + 2 * i];
                expAddrQ.push_back(15'(i));
                expDataQ.push_back(16'(w));
                sum = (sum + w) % 65536;
            end
            chk     = q[2 + 2 * n] * 256 + q[3 + 2 * n];
            expDone = (sum == chk);
            expErr  = (sum != chk);
            expAddr = 15'(n % 32768);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after a random gap; byte_valid stays up while not ready
    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int gap;
        int t;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        repeat (gap) begin
            byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            assertCount++;
            failCount++;
            streamTimeout = 1'b1;
            $display("[TB] FAIL byte_ready_timeout: got no ready in 100 cycles, required ready");
            byte_valid = 1'b0;
        end else begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] q[$], input int maxGap);
        wrAddrQ.delete();
        wrDataQ.delete();
        streamTimeout = 1'b0;
        pulseStart();
        foreach (q[i]) begin
            if (!streamTimeout) sendByte(q[i], maxGap);
        end
        repeat (3) @(negedge clk);
    endtask

    // Compare final flags and every observed write against the model
    task automatic checkImage(input string tag);
        checkOutput({tag, " done"}, 32'(done), 32'(expDone));
        checkOutput({tag, " error"}, 32'(error), 32'(expErr));
        checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!expDone));
        checkOutput({tag, " byte_ready"}, 32'(byte_ready), 32'd0);
        checkOutput({tag, " rom_addr"}, 32'(rom_addr), 32'(expAddr));
        checkOutput({tag, " write_count"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
        for (int i = 0; i < expAddrQ.size() && i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("%s wr%0d addr", tag, i), 32'(wrAddrQ[i]), 32'(expAddrQ[i]));
            checkOutput($sformatf("%s wr%0d data", tag, i), 32'(wrDataQ[i]), 32'(expDataQ[i]));
        end
    endtask

    initial begin
        logic [7:0] q[$];
        vec_t       v;
        int         n;
        int         sum;
        logic [15:0] w;
        logic [15:0] chk;

        vectors[0] = '{stream: 96'h0002_1234_ABCD_BE01_0000_0000, nbytes: 4'd8,
                       expDone: 1'b1, expErr: 1'b0, expWrites: 4'd2, expAddr: 15'd2};
        vectors[1] = '{stream: 96'h0002_1234_ABCD_BE02_0000_0000, nbytes: 4'd8,
                       expDone: 1'b0, expErr: 1'b1, expWrites: 4'd2, expAddr: 15'd2};
        vectors[2] = '{stream: 96'h0002_1234_ABCD_BE01_0000_0000, nbytes: 4'd8,
                       expDone: 1'b1, expErr: 1'b0, expWrites: 4'd2, expAddr: 15'd2};
        vectors[3] = '{stream: 96'h0000_0000_0000_0000_0000_0000, nbytes: 4'd2,
                       expDone: 1'b0, expErr: 1'b1, expWrites: 4'd0, expAddr: 15'd0};
        vectors[4] = '{stream: 96'h8001_0000_0000_0000_0000_0000, nbytes: 4'd2,
                       expDone: 1'b0, expErr: 1'b1, expWrites: 4'd0, expAddr: 15'd0};
        vectors[5] = '{stream: 96'h0001_FFFF_FFFF_0000_0000_0000, nbytes: 4'd6,
                       expDone: 1'b1, expErr: 1'b0, expWrites: 4'd1, expAddr: 15'd1};
        vectors[6] = '{stream: 96'h0003_0001_0002_0003_0006_0000, nbytes: 4'd10,
                       expDone: 1'b1, expErr: 1'b0, expWrites: 4'd3, expAddr: 15'd3};

        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values while reset is held
        checkOutput("rst cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst error", 32'(error), 32'd0);
        checkOutput("rst byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst rom_data", 32'(rom_data), 32'd0);

        // Idle with no start: nothing moves for 20 cycles
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("idle done", 32'(done), 32'd0);
        checkOutput("idle error", 32'(error), 32'd0);
        checkOutput("idle byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("idle writes", 32'(wrAddrQ.size()), 32'd0);

        // Table of whole images
        for (int k = 0; k < 7; k++) begin
            v = vectors[k];
            q.delete();
            for (int i = 0; i < int'(v.nbytes); i++) begin
                q.push_back(v.stream[95 - 8 * i -: 8]);
            end
            modelImage(q);
            applyStimulus(q, 5);
            checkOutput($sformatf("vec%0d done", k), 32'(done), 32'(v.expDone));
            checkOutput($sformatf("vec%0d error", k), 32'(error), 32'(v.expErr));
            checkOutput($sformatf("vec%0d cpu_hold", k), 32'(cpu_hold), 32'(!v.expDone));
            checkOutput($sformatf("vec%0d rom_addr", k), 32'(rom_addr), 32'(v.expAddr));
            checkOutput($sformatf("vec%0d writes", k), 32'(wrAddrQ.size()), 32'(v.expWrites));
            checkImage($sformatf("vec%0d", k));
        end

        // Write latency: strobe appears the cycle right after the low byte
        wrAddrQ.delete();
        wrDataQ.delete();
        streamTimeout = 1'b0;
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h01, 0);
        sendByte(8'h12, 2);
        sendByte(8'h34, 2);
        checkOutput("lat rom_we", 32'(rom_we), 32'd1);
        checkOutput("lat rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("lat rom_data", 32'(rom_data), 32'h1234);
        @(negedge clk);
        checkOutput("lat rom_we_off", 32'(rom_we), 32'd0);
        checkOutput("lat rom_addr_next", 32'(rom_addr), 32'd1);
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        repeat (2) @(negedge clk);
        checkOutput("lat done", 32'(done), 32'd1);
        checkOutput("lat cpu_hold", 32'(cpu_hold), 32'd0);

        // Reset pulsed while a 3-word load sits in DAT_LO
        streamTimeout = 1'b0;
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h03, 0);
        sendByte(8'h11, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        checkOutput("midrst pre byte_ready", 32'(byte_ready), 32'd1);
        checkOutput("midrst pre rom_addr", 32'(rom_addr), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst error", 32'(error), 32'd0);
        checkOutput("midrst byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("midrst rom_we", 32'(rom_we), 32'd0);
        checkOutput("midrst rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("midrst rom_data", 32'(rom_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q.delete();
        q = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h66, 8'h66};
        modelImage(q);
        applyStimulus(q, 3);
        checkImage("postrst");
        checkOutput("postrst done_const", 32'(done), 32'd1);

        // Random images with random gaps, judged by the reference model
        for (int r = 0; r < 10; r++) begin
            q.delete();
            n = int'($urandom_range(6, 1));
            sum = 0;
            q.push_back(8'(n >> 8));
            q.push_back(8'(n));
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                q.push_back(w[15:8]);
                q.push_back(w[7:0]);
                sum = (sum + int'(w)) % 65536;
            end
            chk = 16'(sum);
            if ($urandom_range(3, 0) == 0) chk = chk ^ 16'($urandom_range(65535, 1));
            q.push_back(chk[15:8]);
            q.push_back(chk[7:0]);
            modelImage(q);
            applyStimulus(q, 5);
            checkImage($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Boot-time writer for the Hack instruction ROM.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them to consecutive ROM addresses from 0.
- Holds the CPU (and therefore its program counter) in reset until a checksum-verified image is loaded. The PC and fetch path are the ROM's reader; this block is its writer.

Parameters:
- ADDR_W, 15, ROM address width (32K words).
- MAX_WORDS, 32768, largest accepted image length in words.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle; transfer when byte_valid && byte_ready
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_addr  out  ADDR_W  ROM write address
- rom_data  out  16  ROM write data
- cpu_hold  out  1  drive to CPU/PC reset; high = CPU held
- done  out  1  image loaded and checksum good (level)
- error  out  1  bad length or checksum mismatch (level)

Behaviour:
- Stream format, all values big-endian:
  - LEN_HI, LEN_LO: word count N.
  - N words, each as high byte then low byte.
  - CHK_HI, CHK_LO: sum of all N words mod 2^16.
- States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, DONE, ERR.
- Reset values (async, reset low): state IDLE, rom_we 0, rom_addr 0, rom_data 0, cpu_hold 1, done 0, error 0, byte_ready 0, internal word counter 0, checksum 0.
- byte_ready is 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK_HI and CHK_LO. It is registered and decoded from state.
- IDLE / DONE / ERR + start:
  - go to LEN_HI.
  - clear done, error, checksum and word counter.
  - set rom_addr to 0 and cpu_hold to 1.
- start in any other state is ignored.
- LEN_HI -> LEN_LO on transfer.
- LEN_LO on transfer:
  - if N == 0 or N > MAX_WORDS, go to ERR.
  - otherwise go to DAT_HI.
- DAT_HI -> DAT_LO on transfer; latch the high byte.
- DAT_LO on transfer:
  - go to WRITE.
  - rom_data = {hi, byte_data}.
  - checksum += word, truncated to 16 bits.
- WRITE, exactly one cycle:
  - rom_we = 1 with rom_addr at the current word index.
  - next cycle: rom_addr + 1 and word counter + 1.
  - if counter + 1 == N, go to CHK_HI; else go to DAT_HI.
- Write latency: rom_we is high in the cycle immediately after the low byte transfer.
- rom_addr after the last write equals N mod 2^ADDR_W. At N = 32768 it wraps to 0, which is legal and unused.
- CHK_HI -> CHK_LO on transfer.
- CHK_LO on transfer:
  - if the received checksum equals the computed checksum, go to DONE (done = 1, cpu_hold = 0).
  - otherwise go to ERR (error = 1, cpu_hold stays 1).
- DONE holds until start or reset. ERR holds until start or reset; cpu_hold stays 1.
- byte_valid with byte_ready low: no transfer, byte not consumed. Gaps of any length between bytes are legal.
- Reset asserted mid-load: immediate return to reset values. A partially written ROM is left as is, and the CPU stays held.

Decomposition:
- Shared package (hack_pkg) holds:
  - the state enum/localparams
  - HACK_ROM_ADDR_W = 15
  - HACK_WORD_W = 16
- One natural sub-module: hack_word_assembler, which handles byte-pair to 16-bit word assembly plus running checksum, with clear/load strobes from the FSM.
- The FSM and address counter live in the top module.

Test Plan:
- Reset, no start: cpu_hold 1, done 0, error 0, byte_ready 0, rom_we never asserted over 20 cycles.
- start; stream 00 02 12 34 AB CD BE 01:
  - writes 0x1234 at address 0 and 0xABCD at address 1, each with a one-cycle rom_we.
  - done 1, cpu_hold 0, rom_addr 2.
- Same image with checksum BE 02: both words written, then error 1, done 0, cpu_hold 1. Then start plus a correct image -> done 1.
- Length 00 00 -> ERR after LEN_LO, no rom_we. Length 80 01 (32769) -> ERR.
- Random byte_valid gaps (0-5 idle cycles) on image 00 01 FF FF FF FF: done 1 with 0xFFFF at address 0. Checksum 0xFFFF matches.
- Reset pulsed low while in DAT_LO of a 3-word load:
  - outputs return to reset values asynchronously.
  - a following start plus a full image completes with done 1.
